// File: rtl/connect4_win_scanner.sv
// Connect-4 win checker: walks outward from the dropped cell in four directions through a
// 1-cycle-latency board read port and reports winner, winning direction and draw.
//
// state | meaning
// IDLE  | waiting for an accepted drop
// STEP  | form next cell on current side/direction, bounds check
// READ  | board read request for that cell
// CMP   | compare returned cell contents with the player
// FIN   | publish result, pulse done
module connect4_win_scanner #(
  parameter  int ROWS    = 6,
  parameter  int COLS    = 7,
  parameter  int WIN_LEN = 4,
  localparam int RW      = $clog2(ROWS),
  localparam int CW      = $clog2(COLS),
  localparam int MW      = $clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          start,
  input  logic [RW-1:0] start_row,
  input  logic [CW-1:0] start_col,
  input  logic [1:0]    player,
  output logic          rd_en,
  output logic [RW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  input  logic [1:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic [1:0]    winner,
  output logic [1:0]    win_dir,
  output logic          draw
);
  localparam int              CNTW  = $clog2(WIN_LEN+1);
  localparam logic [MW-1:0]   CELLS = MW'(ROWS*COLS);
  localparam logic [CNTW-1:0] WIN_C = CNTW'(WIN_LEN);

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_READ, S_CMP, S_FIN} state_t;

  state_t             state_q;
  logic [1:0]         player_q, dir_q, winner_q, win_dir_q;
  logic signed [RW:0] org_row_q, cur_row_q, d_row, nxt_row;
  logic signed [CW:0] org_col_q, cur_col_q, d_col, nxt_col;
  logic               side_neg_q, hit_q, busy_q, done_q, rd_en_q, draw_q;
  logic [CNTW-1:0]    cnt_q;
  logic [MW-1:0]      move_cnt_q;
  logic [RW-1:0]      rd_row_q;
  logic [CW-1:0]      rd_col_q;
  logic               oob, end_side;

  // Direction order H, V, D(+1,+1), D(+1,-1) as (row, col) deltas.
  always_comb begin
    d_row = '0;
    d_col = '0;
    case (dir_q)
      2'd0: begin d_row = '0;             d_col = (CW+1)'(1); end
      2'd1: begin d_row = (RW+1)'(1);     d_col = '0;         end
      2'd2: begin d_row = (RW+1)'(1);     d_col = (CW+1)'(1); end
      default: begin d_row = (RW+1)'(1);  d_col = '1;         end
    endcase
  end

  assign nxt_row  = side_neg_q ? cur_row_q - d_row : cur_row_q + d_row;
  assign nxt_col  = side_neg_q ? cur_col_q - d_col : cur_col_q + d_col;
  assign oob      = (int'(nxt_row) < 0) || (int'(nxt_row) >= ROWS) ||
                    (int'(nxt_col) < 0) || (int'(nxt_col) >= COLS);
  assign end_side = ((state_q == S_STEP) && oob) ||
                    ((state_q == S_CMP) && (rd_data != player_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      player_q   <= '0;
      dir_q      <= '0;
      org_row_q  <= '0;
      org_col_q  <= '0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      side_neg_q <= 1'b0;
      hit_q      <= 1'b0;
      cnt_q      <= '0;
      move_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      winner_q   <= '0;
      win_dir_q  <= '0;
      draw_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      if (clear) begin
        move_cnt_q <= '0;
        draw_q     <= 1'b0;
      end
      case (state_q)
        S_IDLE: if (start && !clear) begin
          player_q   <= player;
          org_row_q  <= {1'b0, start_row};
          org_col_q  <= {1'b0, start_col};
          cur_row_q  <= {1'b0, start_row};
          cur_col_q  <= {1'b0, start_col};
          dir_q      <= 2'd0;
          side_neg_q <= 1'b0;
          cnt_q      <= CNTW'(1);
          hit_q      <= 1'b0;
          winner_q   <= '0;
          win_dir_q  <= '0;
          busy_q     <= 1'b1;
          if (player == 2'b01 || player == 2'b10) begin
            state_q <= S_STEP;
            if (move_cnt_q != CELLS) move_cnt_q <= move_cnt_q + MW'(1);
          end else begin
            state_q <= S_FIN;
          end
        end
        S_STEP: if (!oob) begin
          rd_en_q  <= 1'b1;
          rd_row_q <= nxt_row[RW-1:0];
          rd_col_q <= nxt_col[CW-1:0];
          state_q  <= S_READ;
        end
        S_READ: state_q <= S_CMP;
        S_CMP: if (rd_data == player_q) begin
          cur_row_q <= {1'b0, rd_row_q};
          cur_col_q <= {1'b0, rd_col_q};
          cnt_q     <= cnt_q + CNTW'(1);
          if ((cnt_q + CNTW'(1)) == WIN_C) begin
            hit_q   <= 1'b1;
            state_q <= S_FIN;
          end else begin
            state_q <= S_STEP;
          end
        end
        S_FIN: begin
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          winner_q  <= hit_q ? player_q : 2'b00;
          win_dir_q <= hit_q ? dir_q : 2'b00;
          if (!hit_q && !clear && move_cnt_q == CELLS) draw_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // Side exhausted: mirror once, then move on to the next direction.
      if (end_side) begin
        cur_row_q <= org_row_q;
        cur_col_q <= org_col_q;
        if (!side_neg_q) begin
          side_neg_q <= 1'b1;
          state_q    <= S_STEP;
        end else if (dir_q == 2'd3) begin
          state_q <= S_FIN;
        end else begin
          dir_q      <= dir_q + 2'd1;
          side_neg_q <= 1'b0;
          cnt_q      <= CNTW'(1);
          state_q    <= S_STEP;
        end
      end
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_row  = rd_row_q;
  assign rd_col  = rd_col_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign winner  = winner_q;
  assign win_dir = win_dir_q;
  assign draw    = draw_q;

endmodule

// File: tb/tb_connect4_win_scanner.sv
// Directed bench for connect4_win_scanner on the default 6x7 board, win length 4,
// with a behavioural board RAM answering reads one cycle later.
module tb_connect4_win_scanner;
  logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0;
  logic [2:0] start_row = '0, start_col = '0;
  logic [1:0] player = '0, rd_data = '0;
  logic       rd_en, busy, done, draw;
  logic [2:0] rd_row, rd_col;
  logic [1:0] winner, win_dir;
  logic [1:0] board [6][7];
  int         total = 0, bad = 0, rd_cnt = 0, bad_addr = 0;

  always #5 clk = ~clk;

  connect4_win_scanner #(.ROWS(6), .COLS(7), .WIN_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .start_row(start_row), .start_col(start_col), .player(player),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .busy(busy), .done(done), .winner(winner), .win_dir(win_dir), .draw(draw)
  );

  always @(posedge clk)
    if (rd_en && rd_row < 3'd6 && rd_col < 3'd7) rd_data <= board[rd_row][rd_col];

  always @(posedge clk)
    if (rd_en) begin
      rd_cnt = rd_cnt + 1;
      if (rd_row >= 3'd6 || rd_col >= 3'd7) bad_addr = bad_addr + 1;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_board();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) board[r][c] = 2'b00;
  endtask

  task automatic run_scan(input int r, input int c, input logic [1:0] p,
                          output int cyc, output int reads);
    int rd0;
    rd0 = rd_cnt;
    start_row = 3'(r);
    start_col = 3'(c);
    player    = p;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    reads = rd_cnt - rd0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, rds, n, extra, seen;
    clr_board();
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({busy, done, rd_en, winner, win_dir, draw}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    board[0][0] = 2'b01; board[0][1] = 2'b01; board[0][2] = 2'b01;
    run_scan(0, 3, 2'b01, cyc, rds);
    chk("h_winner", 32'(winner), 32'd1);
    chk("h_dir", 32'(win_dir), 32'd0);
    chk("h_reads", 32'(rds), 32'd4);
    chk("h_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("h_done_pulse", 32'(done), 32'd0);
    chk("h_winner_held", 32'(winner), 32'd1);

    clr_board();
    board[0][0] = 2'b01; board[1][0] = 2'b01; board[2][0] = 2'b01;
    run_scan(3, 0, 2'b01, cyc, rds);
    chk("v_winner", 32'(winner), 32'd1);
    chk("v_dir", 32'(win_dir), 32'd1);
    chk("v_reads", 32'(rds), 32'd5);

    clr_board();
    board[1][1] = 2'b10; board[2][2] = 2'b10; board[3][3] = 2'b10;
    run_scan(0, 0, 2'b10, cyc, rds);
    chk("d1_winner", 32'(winner), 32'd2);
    chk("d1_dir", 32'(win_dir), 32'd2);
    chk("d1_reads", 32'(rds), 32'd5);

    clr_board();
    board[1][2] = 2'b10; board[2][1] = 2'b10; board[3][0] = 2'b10;
    run_scan(0, 3, 2'b10, cyc, rds);
    chk("d2_winner", 32'(winner), 32'd2);
    chk("d2_dir", 32'(win_dir), 32'd3);
    chk("d2_reads", 32'(rds), 32'd7);

    clr_board();
    run_scan(5, 6, 2'b01, cyc, rds);
    chk("corner_winner", 32'(winner), 32'd0);
    chk("corner_dir", 32'(win_dir), 32'd0);
    chk("corner_reads", 32'(rds), 32'd3);
    chk("corner_in_bound", 32'(cyc <= 74), 32'd1);

    clr_board();
    board[0][0] = 2'b01; board[0][1] = 2'b01; board[0][3] = 2'b01; board[0][4] = 2'b01;
    run_scan(0, 4, 2'b01, cyc, rds);
    chk("gap_winner", 32'(winner), 32'd0);
    chk("gap_reads", 32'(rds), 32'd6);

    clr_board();
    board[0][0] = 2'b01; board[0][1] = 2'b01; board[0][2] = 2'b01;
    start_row = 3'd5; start_col = 3'd6; player = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ign_busy", 32'(busy), 32'd1);
    start_row = 3'd0; start_col = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_winner", 32'(winner), 32'd0);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("ign_extra_done", 32'(extra), 32'd0);

    run_scan(0, 3, 2'b11, cyc, rds);
    chk("inv_winner", 32'(winner), 32'd0);
    chk("inv_reads", 32'(rds), 32'd0);

    clear = 1'b1; start = 1'b1; start_row = 3'd0; start_col = 3'd3; player = 2'b01;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    chk("clr_start_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("clr_start_no_done", 32'(done), 32'd0);

    clr_board();
    for (int i = 0; i < 42; i++) begin
      run_scan(i / 7, i % 7, 2'b01, cyc, rds);
      if (i == 40) chk("draw_before_full", 32'(draw), 32'd0);
      if (i == 41) begin
        chk("draw_full", 32'(draw), 32'd1);
        chk("draw_winner", 32'(winner), 32'd0);
      end
    end
    run_scan(2, 3, 2'b10, cyc, rds);
    chk("draw_sticky", 32'(draw), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("draw_cleared", 32'(draw), 32'd0);

    board[0][0] = 2'b01; board[0][1] = 2'b01; board[0][2] = 2'b01;
    run_scan(0, 3, 2'b01, cyc, rds);
    chk("pre_rst_winner", 32'(winner), 32'd1);
    start_row = 3'd5; start_col = 3'd6; player = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    n = 0;
    while (seen == 0 && n < 20) begin
      if (rd_en) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_rd_en_seen", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid", 32'({busy, done, rd_en, winner, win_dir, draw}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_scan(0, 3, 2'b01, cyc, rds);
    chk("post_rst_winner", 32'(winner), 32'd1);
    chk("no_oob_reads", 32'(bad_addr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
